dcache_miss_ctrl: RTL and testbench
===================================

Name: dcache_miss_ctrl

Overview:
- Miss-handling sequencer for the data cache.
- Takes the tag-compare hit/miss result for each CPU request and stalls the pipeline on a miss.
- Picks a victim way round-robin, writes back the victim line if it is dirty, then burst-refills the line and writes it into the data/tag RAMs.
- Sits between the dcache lookup stage and the AXI-bridge read/write burst ports.

Parameters:
- WAY_NUM, 4, number of ways (power of two, ≥2).
- LINE_WORDS, 8, 32-bit words per line (power of two).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- cpu_req  in  1  lookup valid this cycle
- cpu_addr  in  ADDR_W  request address (stable while stall=1)
- hit  in  1  tag match in any way
- victim_dirty  in  1  dirty bit of the way on victim_way
- victim_tag_addr  in  ADDR_W  line-aligned address of the victim line
- stall  out  1  freeze the CPU pipeline
- victim_way  out  $clog2(WAY_NUM)  way selected for replacement
- wr_req  out  1  writeback address request
- wr_addr  out  ADDR_W  writeback line address
- wr_ready  in  1  writeback address accepted
- wr_valid  out  1  writeback word valid
- wr_word_idx  out  $clog2(LINE_WORDS)  word index to read from data RAM
- wr_last  out  1  final writeback word
- wr_wready  in  1  writeback word accepted
- wr_done  in  1  write response received
- rd_req  out  1  refill request
- rd_addr  out  ADDR_W  line-aligned refill address
- rd_ready  in  1  refill request accepted
- ret_valid  in  1  refill word valid
- ret_last  in  1  final refill word
- refill_we  out  1  write a returned word to data RAM
- refill_word_idx  out  $clog2(LINE_WORDS)  word index of the returned word
- tag_we  out  1  write tag/valid (clear dirty) for victim_way
- busy  out  1  FSM not in IDLE

Behaviour:
- States: IDLE, WB_ADDR, WB_DATA, WB_RESP, RF_ADDR, RF_DATA, RF_FIN.
- Reset (resetn=0 on a clk edge): state=IDLE, RR pointer=0, word counter=0. All outputs 0, except victim_way=0.
- IDLE:
  - cpu_req&hit: stall=0, no transition. The RR pointer does not move on hits.
  - cpu_req&!hit: stall=1 combinationally in the same cycle. Latch line address cpu_addr & ~(LINE_WORDS*4-1) and the victim way.
    - Next state WB_ADDR if victim_dirty, else RF_ADDR.
- WB_ADDR: wr_req=1, wr_addr=victim_tag_addr (latched). On wr_ready go to WB_DATA with counter=0.
- WB_DATA:
  - wr_valid=1, wr_word_idx=counter.
  - Counter increments on each wr_wready.
  - wr_last=1 when counter==LINE_WORDS-1. wr_last&wr_wready goes to WB_RESP.
- WB_RESP: wait for wr_done, then go to RF_ADDR.
- RF_ADDR: rd_req=1, rd_addr=latched line address. On rd_ready go to RF_DATA with counter=0.
- RF_DATA:
  - Each ret_valid: refill_we=1, refill_word_idx=counter, counter+1 (wraps to 0).
  - ret_valid&ret_last goes to RF_FIN.
  - ret_last before counter==LINE_WORDS-1 is a bus error: still go to RF_FIN. Words that did not arrive are not written.
- RF_FIN:
  - tag_we=1 for one cycle; advance the RR pointer (LINE_WORDS-1 wraps to 0 analogously: WAY_NUM-1 wraps to 0).
  - Next state IDLE. stall stays 1 through RF_FIN and drops in the following IDLE cycle. The CPU then replays the request and hits.
- stall=1 in every state except IDLE.
- victim_way is held constant from the miss cycle until RF_FIN completes.
- Handshakes:
  - req/valid stay asserted until accepted.
  - A ready arriving in the same cycle the request first asserts is accepted; this gives single-cycle address phases.
- Reset mid-burst: return to IDLE immediately and drop all requests. The bus bridge is reset by the same resetn.
- cpu_req ignored outside IDLE.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs perf_hit_cnt, perf_miss_cnt, perf_wb_cnt.
  - Each counter increments on, respectively: IDLE cpu_req&hit, IDLE cpu_req&!hit, entry into WB_ADDR.
  - Counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - the typedef enum for miss_state_t;
  - localparams OFFSET_W=$clog2(LINE_WORDS*4), WAY_W=$clog2(WAY_NUM);
  - the line-address mask function.
- Sub-module dcache_victim_sel: RR pointer register with advance input and victim_way output, parameterised by WAY_NUM.

Test Plan:
- Reset, then hits at 0x100, 0x104 -> stall=0, busy=0, victim_way stays 0.
- Clean miss at 0x1234 -> rd_addr=0x1220, 8 ret_valid words with refill_word_idx 0..7, tag_we one cycle, stall drops, victim_way advances to 1.
- Dirty miss with victim_tag_addr=0x8000 -> wr_addr=0x8000, 8 wr_valid beats, wr_last on idx 7, WB_RESP waits for wr_done, then refill.
- Four consecutive clean misses -> victim_way 0,1,2,3, then back to 0.
- wr_wready toggled every other cycle and rd_ready delayed 5 cycles -> no beat lost or duplicated, reqs held until ready.
- resetn=0 during RF_DATA word 3 -> next cycle state IDLE, rd_req=0, stall=0, pointer=0.
- Early ret_last at word 5 -> RF_FIN entered, tag_we pulses, no further refill_we.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, default geometry and line-address helper for the dcache miss path
package dcache_pkg;
  typedef enum logic [2:0] {IDLE, WB_ADDR, WB_DATA, WB_RESP, RF_ADDR, RF_DATA, RF_FIN} miss_state_t;
  localparam int DEF_WAY_NUM = 4;
  localparam int DEF_LINE_WORDS = 8;
  localparam int OFFSET_W = $clog2(DEF_LINE_WORDS * 4);
  localparam int WAY_W = $clog2(DEF_WAY_NUM);
  function automatic logic [63:0] line_mask(input logic [63:0] addr, input int off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction
endpackage

// File: rtl/dcache_victim_sel.sv
// dcache_victim_sel: round-robin replacement pointer
//   clk, resetn : clock, synchronous active-low reset (pointer -> 0)
//   advance     : step the pointer once, wrapping WAY_NUM-1 -> 0
//   way         : current victim way
module dcache_victim_sel #(
  parameter int WAY_NUM = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       advance,
  output logic [$clog2(WAY_NUM)-1:0] way
);
  always_ff @(posedge clk)
    if (!resetn) way <= '0;
    else if (advance) way <= way + 1'b1;
endmodule

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: dcache miss sequencer (stall, dirty writeback, burst refill, tag update)
//   CPU side  : cpu_req/cpu_addr/hit in, stall out
//   victim    : victim_dirty/victim_tag_addr in, victim_way out
//   writeback : wr_req/wr_addr/wr_ready, wr_valid/wr_word_idx/wr_last/wr_wready, wr_done
//   refill    : rd_req/rd_addr/rd_ready, ret_valid/ret_last, refill_we/refill_word_idx
//   tag_we, busy
//   Optional DCACHE_PERF_CNT_EN adds saturating perf_hit_cnt/perf_miss_cnt/perf_wb_cnt.
module dcache_miss_ctrl
  import dcache_pkg::*;
#(
  parameter int WAY_NUM    = 4,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cpu_req,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic                          hit,
  input  logic                          victim_dirty,
  input  logic [ADDR_W-1:0]             victim_tag_addr,
  output logic                          stall,
  output logic [$clog2(WAY_NUM)-1:0]    victim_way,
  output logic                          wr_req,
  output logic [ADDR_W-1:0]             wr_addr,
  input  logic                          wr_ready,
  output logic                          wr_valid,
  output logic [$clog2(LINE_WORDS)-1:0] wr_word_idx,
  output logic                          wr_last,
  input  logic                          wr_wready,
  input  logic                          wr_done,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rd_ready,
  input  logic                          ret_valid,
  input  logic                          ret_last,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word_idx,
  output logic                          tag_we,
  output logic                          busy
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_hit_cnt,
  output logic [31:0]                   perf_miss_cnt,
  output logic [31:0]                   perf_wb_cnt
`endif
);
  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int CW = $clog2(LINE_WORDS);
  miss_state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] line_q, wb_q;
  logic miss, last_word;
  assign miss = cpu_req && !hit;
  assign last_word = cnt == CW'(LINE_WORDS - 1);
  dcache_victim_sel #(.WAY_NUM(WAY_NUM)) u_victim (
    .clk(clk),
    .resetn(resetn),
    .advance(state == RF_FIN),
    .way(victim_way)
  );
  always_ff @(posedge clk)
    if (!resetn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (miss) nxt = victim_dirty ? WB_ADDR : RF_ADDR;
      WB_ADDR: if (wr_ready) nxt = WB_DATA;
      WB_DATA: if (wr_wready && last_word) nxt = WB_RESP;
      WB_RESP: if (wr_done) nxt = RF_ADDR;
      RF_ADDR: if (rd_ready) nxt = RF_DATA;
      RF_DATA: if (ret_valid && ret_last) nxt = RF_FIN;
      RF_FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    stall = state != IDLE || miss;
    busy = state != IDLE;
    wr_req = state == WB_ADDR;
    wr_addr = wb_q;
    wr_valid = state == WB_DATA;
    wr_word_idx = cnt;
    wr_last = state == WB_DATA && last_word;
    rd_req = state == RF_ADDR;
    rd_addr = line_q;
    refill_we = state == RF_DATA && ret_valid;
    refill_word_idx = cnt;
    tag_we = state == RF_FIN;
  end
  // Counter is held at zero outside the burst states, so every burst starts at word 0.
  always_comb
    cnt_nxt = (state == WB_DATA && wr_wready) || (state == RF_DATA && ret_valid) ? cnt + 1'b1 :
              (state == WB_DATA || state == RF_DATA) ? cnt : '0;
  always_ff @(posedge clk)
    if (!resetn) begin
      cnt <= '0;
      line_q <= '0;
      wb_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (state == IDLE && miss) begin
        line_q <= ADDR_W'(line_mask(64'(cpu_addr), OFF_W));
        wb_q <= victim_tag_addr;
      end
    end
`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!resetn) begin
      perf_hit_cnt <= '0;
      perf_miss_cnt <= '0;
      perf_wb_cnt <= '0;
    end else if (state == IDLE && cpu_req) begin
      if (hit) perf_hit_cnt <= perf_hit_cnt + 32'(perf_hit_cnt != '1);
      else perf_miss_cnt <= perf_miss_cnt + 32'(perf_miss_cnt != '1);
      if (!hit && victim_dirty) perf_wb_cnt <= perf_wb_cnt + 32'(perf_wb_cnt != '1);
    end
`endif
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: directed self-checking bench for dcache_miss_ctrl
module tb_dcache_miss_ctrl;
  logic clk = 0, resetn = 0, cpu_req = 0, hit = 0, victim_dirty = 0;
  logic [31:0] cpu_addr = 0, victim_tag_addr = 0;
  logic wr_ready = 0, wr_wready = 0, wr_done = 0, rd_ready = 0, ret_valid = 0, ret_last = 0;
  logic stall, wr_req, wr_valid, wr_last, rd_req, refill_we, tag_we, busy;
  logic [1:0] victim_way;
  logic [2:0] wr_word_idx, refill_word_idx;
  logic [31:0] wr_addr, rd_addr;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt, perf_wb_cnt;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  dcache_miss_ctrl dut (
    .clk(clk), .resetn(resetn), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .hit(hit),
    .victim_dirty(victim_dirty), .victim_tag_addr(victim_tag_addr), .stall(stall),
    .victim_way(victim_way), .wr_req(wr_req), .wr_addr(wr_addr), .wr_ready(wr_ready),
    .wr_valid(wr_valid), .wr_word_idx(wr_word_idx), .wr_last(wr_last), .wr_wready(wr_wready),
    .wr_done(wr_done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .ret_valid(ret_valid), .ret_last(ret_last), .refill_we(refill_we),
    .refill_word_idx(refill_word_idx), .tag_we(tag_we), .busy(busy)
`ifdef DCACHE_PERF_CNT_EN
    , .perf_hit_cnt(perf_hit_cnt), .perf_miss_cnt(perf_miss_cnt), .perf_wb_cnt(perf_wb_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic miss_start(input logic [31:0] a, input logic d, input logic [31:0] vt, input int way);
    cpu_req = 1; hit = 0; cpu_addr = a; victim_dirty = d; victim_tag_addr = vt;
    #1 chk("miss_stall_comb", 32'(stall), 1);
    chk("miss_victim_way", 32'(victim_way), 32'(way));
    tick;
    cpu_req = 0; victim_dirty = 0;
    #1 chk("miss_busy", 32'(busy), 1);
  endtask
  task automatic refill(input int n, input int way);
    chk("rf_rd_req", 32'(rd_req), 1);
    rd_ready = 1;
    tick;
    rd_ready = 0;
    for (int i = 0; i < n; i++) begin
      ret_valid = 1; ret_last = (i == n - 1);
      #1 chk("rf_we", 32'(refill_we), 1);
      chk("rf_idx", 32'(refill_word_idx), 32'(i));
      tick;
    end
    ret_valid = 1; ret_last = 0;
    #1 chk("fin_tag_we", 32'(tag_we), 1);
    chk("fin_no_we", 32'(refill_we), 0);
    chk("fin_stall", 32'(stall), 1);
    chk("fin_way", 32'(victim_way), 32'(way));
    tick;
    ret_valid = 0;
    #1 chk("idle_tag_we", 32'(tag_we), 0);
    chk("idle_stall", 32'(stall), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_way_adv", 32'(victim_way), 32'((way + 1) % 4));
  endtask
  task automatic wb_burst(input logic [31:0] vt);
    chk("wb_req", 32'(wr_req), 1);
    chk("wb_addr", wr_addr, vt);
    wr_ready = 1;
    tick;
    wr_ready = 0;
    for (int i = 0; i < 8; i++) begin
      wr_wready = 1;
      #1 chk("wb_valid", 32'(wr_valid), 1);
      chk("wb_idx", 32'(wr_word_idx), 32'(i));
      chk("wb_last", 32'(wr_last), 32'(i == 7));
      tick;
    end
    wr_wready = 0;
    #1 chk("wbresp_valid", 32'(wr_valid), 0);
    chk("wbresp_rd_req", 32'(rd_req), 0);
    tick;
    #1 chk("wbresp_wait", 32'(rd_req), 0);
    chk("wbresp_stall", 32'(stall), 1);
    wr_done = 1;
    tick;
    wr_done = 0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick; tick;
    #1 chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_way", 32'(victim_way), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_tag_we", 32'(tag_we), 0);
    resetn = 1;
    tick;
    cpu_req = 1; hit = 1; cpu_addr = 32'h100;
    #1 chk("hit0_stall", 32'(stall), 0);
    tick;
    cpu_addr = 32'h104;
    #1 chk("hit1_stall", 32'(stall), 0);
    chk("hit1_busy", 32'(busy), 0);
    tick;
    cpu_req = 0;
    #1 chk("hit_way", 32'(victim_way), 0);
    chk("hit_busy", 32'(busy), 0);
    miss_start(32'h1234, 0, 32'h0, 0);
    chk("clean_rd_addr", rd_addr, 32'h1220);
    chk("clean_no_wr", 32'(wr_req), 0);
    refill(8, 0);
    miss_start(32'h2000, 1, 32'h8000, 1);
    wb_burst(32'h8000);
    chk("dirty_rd_addr", rd_addr, 32'h2000);
    refill(8, 1);
    for (int k = 0; k < 4; k++) begin
      miss_start(32'h4000 + 32'(k) * 32'h40 + 32'h1c, 0, 32'h0, (2 + k) % 4);
      chk("seq_rd_addr", rd_addr, 32'h4000 + 32'(k) * 32'h40);
      refill(8, (2 + k) % 4);
    end
    miss_start(32'h5008, 1, 32'h9040, 2);
    for (int c = 0; c < 3; c++) begin
      chk("tog_wr_req_hold", 32'(wr_req), 1);
      tick; #1;
    end
    chk("tog_wr_addr", wr_addr, 32'h9040);
    wr_ready = 1;
    tick;
    wr_ready = 0;
    begin
      int exp_idx = 0;
      for (int c = 0; exp_idx < 8 && c < 40; c++) begin
        wr_wready = c[0];
        #1 chk("tog_valid", 32'(wr_valid), 1);
        chk("tog_idx", 32'(wr_word_idx), 32'(exp_idx));
        chk("tog_last", 32'(wr_last), 32'(exp_idx == 7));
        tick;
        if (c[0]) exp_idx++;
      end
    end
    wr_wready = 0;
    #1 chk("tog_done_valid", 32'(wr_valid), 0);
    wr_done = 1;
    tick;
    wr_done = 0;
    for (int c = 0; c < 5; c++) begin
      #1 chk("tog_rd_req_hold", 32'(rd_req), 1);
      tick;
    end
    #1 chk("tog_rd_addr", rd_addr, 32'h5000);
    refill(8, 2);
    miss_start(32'h6010, 0, 32'h0, 3);
    rd_ready = 1;
    tick;
    rd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      ret_valid = 1;
      tick;
    end
    #1 chk("rst_mid_idx", 32'(refill_word_idx), 3);
    resetn = 0;
    tick;
    resetn = 1; ret_valid = 0;
    #1 chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_rd_req", 32'(rd_req), 0);
    chk("rst_mid_way", 32'(victim_way), 0);
    chk("rst_mid_we", 32'(refill_we), 0);
    tick;
    miss_start(32'h7020, 0, 32'h0, 0);
    chk("early_rd_addr", rd_addr, 32'h7020);
    refill(6, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
